// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, FSM encoding and border test for the LBP histogram
package lbp_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int ADDR_W    = 14;
  localparam int NUM_BINS  = 256;
  localparam int BIN_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Row-major address: row = addr / IMG_W, col = addr % IMG_W.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = addr / ADDR_W'(IMG_W);
    col = addr % ADDR_W'(IMG_W);
    return (row == '0) || (row == ADDR_W'(IMG_H - 1)) ||
           (col == '0) || (col == ADDR_W'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// rtl/lbp_hist_ram.sv - 256-entry bin store, async read, sync write, sync clear
module lbp_hist_ram
  import lbp_pkg::*;
#(
  parameter int BIN_W = 15
) (
  input  logic                 clk,
  input  logic                 resetn_i,
  input  logic [BIN_IDX_W-1:0] rd_addr_i,
  output logic [BIN_W-1:0]     rd_data_o,
  input  logic                 wr_en_i,
  input  logic [BIN_IDX_W-1:0] wr_addr_i,
  input  logic [BIN_W-1:0]     wr_data_i
);

  logic [BIN_W-1:0] mem_q [NUM_BINS];

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      mem_q <= '{default: '0};
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lbp_histogram.sv
// rtl/lbp_histogram.sv - LBP code histogram with 3-stage update pipeline and dump port
// Optional: LBP_HIST_BORDER_SKIP_EN drops samples on the image border.
module lbp_histogram
  import lbp_pkg::*;
#(
  parameter int BIN_W = 15,
  parameter int TOT_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [7:0]        hist_bin,
  output logic [BIN_W-1:0]  hist_count,
  output logic [TOT_W-1:0]  hist_total,
  output logic              hist_done
);

  state_e state_q, state_d;
  logic   drain_q, drain_d;

  logic                 s1_valid_q, s1_valid_d;
  logic [BIN_IDX_W-1:0] s1_bin_q, s1_bin_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [BIN_IDX_W-1:0] s2_bin_q, s2_bin_d;
  logic [BIN_W-1:0]     s2_cnt_q, s2_cnt_d;
  logic [TOT_W-1:0]     total_q, total_d;
  logic [BIN_IDX_W-1:0] k_q, k_d;
  logic [BIN_W-1:0]     count_q, count_d;

  logic                 accum_en;
  logic                 dump_en;
  logic                 done_o;
  logic                 sample_ok;
  logic                 s3_valid;
  logic [BIN_IDX_W-1:0] s3_bin;
  logic [BIN_W-1:0]     s3_cnt;
  logic [BIN_IDX_W-1:0] rd_addr;
  logic [BIN_W-1:0]     rd_data;
  logic [BIN_W-1:0]     fwd_cnt;
  logic                 beat_accept;
  logic                 dump_load;

`ifdef LBP_HIST_BORDER_SKIP_EN
  assign sample_ok = lbp_valid && !is_border(lbp_addr);
`else
  logic unused_addr;
  assign unused_addr = ^lbp_addr;
  assign sample_ok   = lbp_valid;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_ACCUM;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = (state_q == ST_DRAIN);
    unique case (state_q)
      ST_ACCUM: if (finish) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q) state_d = ST_DUMP;
      ST_DUMP:  if (beat_accept && (k_q == 8'd255)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    accum_en = (state_q == ST_ACCUM);
    dump_en  = (state_q == ST_DUMP);
    done_o   = (state_q == ST_DONE);
  end

  // S3 is the write itself; its result is forwarded to any reader of the same bin this cycle.
  assign s3_valid    = s2_valid_q;
  assign s3_bin      = s2_bin_q;
  assign s3_cnt      = (&s2_cnt_q) ? s2_cnt_q : s2_cnt_q + BIN_W'(1);
  assign beat_accept = dump_en && hist_ready;
  assign dump_load   = (state_q == ST_DRAIN) && drain_q;
  assign rd_addr     = s1_valid_q ? s1_bin_q : (beat_accept ? k_q + 8'd1 : k_q);
  assign fwd_cnt     = (s3_valid && (s3_bin == rd_addr)) ? s3_cnt : rd_data;

  lbp_hist_ram #(.BIN_W(BIN_W)) u_ram (
    .clk       (clk),
    .resetn_i  (reset),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (s3_valid),
    .wr_addr_i (s3_bin),
    .wr_data_i (s3_cnt)
  );

  always_comb begin
    s1_valid_d = accum_en && sample_ok;
    s1_bin_d   = lbp_data;
    s2_valid_d = s1_valid_q;
    s2_bin_d   = s1_bin_q;
    s2_cnt_d   = fwd_cnt;
    total_d    = total_q;
    if (s3_valid && !(&total_q)) total_d = total_q + TOT_W'(1);
    k_d        = k_q;
    count_d    = count_q;
    if (dump_load) begin
      count_d = fwd_cnt;
    end else if (beat_accept) begin
      k_d     = k_q + 8'd1;
      count_d = fwd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_cnt_q   <= '0;
      total_q    <= '0;
      k_q        <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bin_q   <= s1_bin_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_cnt_q   <= s2_cnt_d;
      total_q    <= total_d;
      k_q        <= k_d;
      count_q    <= count_d;
    end
  end

  assign hist_valid = dump_en;
  assign hist_done  = done_o;
  assign hist_bin   = k_q;
  assign hist_count = count_q;
  assign hist_total = total_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// tb/tb_lbp_histogram.sv - self-checking bench for lbp_histogram at BIN_W=15 and BIN_W=4
module tb_lbp_histogram;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        hist_ready = 1'b0;

  logic        hist_valid, hist_done, hist_valid4, hist_done4;
  logic [7:0]  hist_bin, hist_bin4;
  logic [14:0] hist_count, hist_total, hist_total4;
  logic [3:0]  hist_count4;

  int exp_bins [256];
  int exp_total;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lbp_histogram dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
    .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
    .hist_total(hist_total), .hist_done(hist_done)
  );

  lbp_histogram #(.BIN_W(4)) dut4 (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid4),
    .hist_ready(hist_ready), .hist_bin(hist_bin4), .hist_count(hist_count4),
    .hist_total(hist_total4), .hist_done(hist_done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit on_border(input int addr);
    int row, col;
    row = addr / 128;
    col = addr % 128;
    return (row == 0) || (row == 127) || (col == 0) || (col == 127);
  endfunction

  task automatic model_clear();
    foreach (exp_bins[i]) exp_bins[i] = 0;
    exp_total = 0;
  endtask

  task automatic model_add(input int addr, input int code);
`ifdef LBP_HIST_BORDER_SKIP_EN
    if (on_border(addr)) return;
`endif
    exp_bins[code]++;
    exp_total++;
  endtask

  // One input cycle; counted only when the design is accumulating (caller's responsibility).
  task automatic send(input bit v, input int addr, input int code, input bit fin, input bit counted);
    lbp_valid = v;
    lbp_addr  = 14'(addr);
    lbp_data  = 8'(code);
    finish    = fin;
    tick();
    if (v && counted) model_add(addr, code);
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, hist_valid, 0);
    chk({tag, "_bin"}, hist_bin, 0);
    chk({tag, "_count"}, hist_count, 0);
    chk({tag, "_total"}, hist_total, 0);
    chk({tag, "_done"}, hist_done, 0);
    chk({tag, "_count4"}, hist_count4, 0);
  endtask

  // mode 0: ready always 1, 1: toggling 1/0, 2: random. abort_at >= 0 resets at that bin.
  task automatic do_dump(input int mode, input int abort_at);
    int k, n;
    bit rdy;
    n = 0;
    while (hist_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("dump_start", hist_valid, 1);
    if (hist_valid !== 1'b1) return;
    chk("total", hist_total, sat(exp_total, 32767));
    chk("total4", hist_total4, sat(exp_total, 32767));
    chk("done_early", hist_done, 0);
    k = 0;
    for (int cyc = 0; cyc < 2000 && k < 256; cyc++) begin
      chk("beat_valid", hist_valid, 1);
      chk("beat_bin", hist_bin, k);
      chk("beat_count", hist_count, sat(exp_bins[k], 32767));
      chk("beat_count4", hist_count4, sat(exp_bins[k], 15));
      if (k == abort_at) begin
        do_reset();
        check_idle("abort");
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      hist_ready = rdy;
      tick();
      if (rdy) k++;
    end
    hist_ready = 1'b0;
    chk("beats", k, 256);
    chk("done", hist_done, 1);
    chk("done4", hist_done4, 1);
    chk("valid_off", hist_valid, 0);
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    check_idle("reset");
    reset = 1'b1;
    tick();
    check_idle("accum_idle");

    // Full frame of code 5 in raster order.
    for (int a = 0; a < 16384; a++) send(1'b1, a, 5, a == 16383, 1'b1);
`ifdef LBP_HIST_BORDER_SKIP_EN
    chk("frame_expect", exp_total, 15876);
`else
    chk("frame_expect", exp_total, 16384);
`endif
    do_dump(0, -1);
    do_reset();

    // Back-to-back same-bin stream, then dense random low codes, sample on finish, ignored drain input.
    begin
      int codes [5] = '{7, 7, 7, 9, 7};
      foreach (codes[i]) send(1'b1, 129 + i, codes[i], 1'b0, 1'b1);
    end
    for (int i = 0; i < 300; i++)
      send($urandom_range(0, 3) != 0, $urandom_range(0, 16383), $urandom_range(0, 3), 1'b0, 1'b1);
    send(1'b1, 1000, 2, 1'b1, 1'b1);
    send(1'b1, 1001, 2, 1'b0, 1'b0);
    send(1'b1, 1002, 2, 1'b1, 1'b0);
    do_dump(1, -1);
    do_reset();

    // Saturation of the 4-bit instance, then abort mid-dump.
    for (int i = 0; i < 20; i++) send(1'b1, 129 + i, 3, 1'b0, 1'b1);
    send(1'b0, 0, 0, 1'b1, 1'b0);
    chk("sat_expect", exp_bins[3], 20);
    do_dump(2, 100);

    // Fresh frame after abort.
    for (int i = 0; i < 500; i++)
      send($urandom_range(0, 7) != 0, $urandom_range(0, 16383), $urandom_range(0, 255), 1'b0, 1'b1);
    send(1'b1, 300, 255, 1'b1, 1'b1);
    do_dump(0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
